// File: rtl/instr_queue_multi_issue.sv
`default_nettype none
// =============================================================================
// Module  : instr_queue_multi_issue
// Brief   : Fetch-to-issue instruction queue with PC tracking and a separate
//           predicted-target FIFO; requests replay when storage runs out.
// Revision: 1.0
// =============================================================================
module instr_queue_multi_issue #(
  parameter int unsigned INSTR_PER_FETCH = 4,
  parameter int unsigned ISSUE_WIDTH     = 2,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned ADDR_DEPTH      = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [INSTR_PER_FETCH*32-1:0]        instr_i,
  input  logic [INSTR_PER_FETCH*64-1:0]        addr_i,
  input  logic [INSTR_PER_FETCH-1:0]           valid_i,
  input  logic                                 exception_i,
  input  logic [63:0]                          predict_address_i,
  input  logic [INSTR_PER_FETCH-1:0]           taken_i,
  output logic [$clog2(INSTR_PER_FETCH)-1:0]   branch_index_o,
  output logic                                 replay_o,
  output logic [63:0]                          replay_addr_o,
  output logic [ISSUE_WIDTH*32-1:0]            fetch_instr_o,
  output logic [ISSUE_WIDTH*64-1:0]            fetch_addr_o,
  output logic [ISSUE_WIDTH-1:0]               fetch_ex_o,
  output logic [ISSUE_WIDTH-1:0]               fetch_cf_o,
  output logic [ISSUE_WIDTH*64-1:0]            fetch_predict_addr_o,
  output logic [ISSUE_WIDTH-1:0]               fetch_valid_o,
  input  logic [ISSUE_WIDTH-1:0]               fetch_ack_i
);

  localparam int unsigned IDXW  = $clog2(INSTR_PER_FETCH);
  localparam int unsigned PTRW  = $clog2(DEPTH);
  localparam int unsigned CNTW  = $clog2(DEPTH + 1);
  localparam int unsigned APTRW = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1;
  localparam int unsigned ACNTW = $clog2(ADDR_DEPTH + 1);
  localparam logic [ISSUE_WIDTH-1:0] ACK_ONE = 1;

  logic [CNTW-1:0]  count_q,  count_d;
  logic [PTRW-1:0]  head_q,   head_d;
  logic [PTRW-1:0]  tail_q,   tail_d;
  logic [ACNTW-1:0] acount_q, acount_d;
  logic [APTRW-1:0] ahead_q,  ahead_d;
  logic [APTRW-1:0] atail_q,  atail_d;

  logic [31:0] instr_q [DEPTH];
  logic [31:0] instr_d [DEPTH];
  logic [63:0] addr_q  [DEPTH];
  logic [63:0] addr_d  [DEPTH];
  logic        ex_q    [DEPTH];
  logic        ex_d    [DEPTH];
  logic        cf_q    [DEPTH];
  logic        cf_d    [DEPTH];
  logic [63:0] paddr_q [ADDR_DEPTH];
  logic [63:0] paddr_d [ADDR_DEPTH];

  logic                        has_taken;
  logic [IDXW-1:0]             first_taken;
  logic [INSTR_PER_FETCH-1:0]  elig;
  logic                        push_target;
  logic                        replay_raw;
  logic [63:0]                 replay_addr_raw;
  int                          accept;
  int                          npop;
  int                          apop;

  function automatic logic [APTRW-1:0] aidx(input logic [APTRW-1:0] base, input int off);
    aidx = APTRW'((int'(base) + off) % ADDR_DEPTH);
  endfunction

  // Packet analysis: eligible slots, accepted count and replay request.
  always_comb begin
    int  lead;
    int  elig_cnt;
    int  free;
    logic run;
    logic found;
    logic taken_in;

    has_taken   = 1'b0;
    first_taken = '0;
    for (int i = INSTR_PER_FETCH - 1; i >= 0; i--) begin
      if (taken_i[i] && valid_i[i]) begin
        has_taken   = 1'b1;
        first_taken = IDXW'(i);
      end
    end

    elig = '0;
    if (exception_i) begin
      elig[0] = valid_i[0];
    end else begin
      for (int i = 0; i < INSTR_PER_FETCH; i++) begin
        elig[i] = valid_i[i] && (!has_taken || (i <= int'(first_taken)));
      end
    end

    lead     = 0;
    elig_cnt = 0;
    run      = 1'b1;
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      if (elig[i]) elig_cnt++;
      if (run && elig[i]) lead++;
      else run = 1'b0;
    end

    // Pops in the same cycle do not free space for this packet.
    free   = int'(DEPTH) - int'(count_q);
    accept = (lead < free) ? lead : free;

    taken_in = !exception_i && has_taken && (int'(first_taken) < accept);
    if (taken_in && (int'(acount_q) == int'(ADDR_DEPTH))) begin
      accept   = int'(first_taken);
      taken_in = 1'b0;
    end
    push_target = taken_in;

    replay_raw      = elig_cnt > accept;
    replay_addr_raw = '0;
    found           = 1'b0;
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      if (!found && elig[i] && (i >= accept)) begin
        found           = 1'b1;
        replay_addr_raw = addr_i[i*64 +: 64];
      end
    end
  end

  assign branch_index_o = first_taken;
  assign replay_o       = replay_raw && !flush_i;
  assign replay_addr_o  = replay_o ? replay_addr_raw : 64'd0;

  // Output lanes; each cf lane consumes the next predicted target in order.
  always_comb begin
    logic [PTRW-1:0] idx;
    int              cf_before;

    fetch_instr_o        = '0;
    fetch_addr_o         = '0;
    fetch_ex_o           = '0;
    fetch_cf_o           = '0;
    fetch_predict_addr_o = '0;
    fetch_valid_o        = '0;
    npop                 = 0;
    apop                 = 0;
    cf_before            = 0;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      idx                           = head_q + PTRW'(j);
      fetch_valid_o[j]              = int'(count_q) > j;
      fetch_instr_o[j*32 +: 32]     = instr_q[idx];
      fetch_addr_o[j*64 +: 64]      = addr_q[idx];
      fetch_ex_o[j]                 = ex_q[idx];
      fetch_cf_o[j]                 = cf_q[idx];
      fetch_predict_addr_o[j*64 +: 64] = paddr_q[aidx(ahead_q, cf_before)];
      if (fetch_ack_i[j]) begin
        npop++;
        if (cf_q[idx]) apop++;
      end
      if (cf_q[idx]) cf_before++;
    end
  end

  always_comb begin
    logic [PTRW-1:0] widx;

    count_d  = count_q;
    head_d   = head_q;
    tail_d   = tail_q;
    acount_d = acount_q;
    ahead_d  = ahead_q;
    atail_d  = atail_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    ex_d     = ex_q;
    cf_d     = cf_q;
    paddr_d  = paddr_q;
    widx     = '0;

    if (flush_i) begin
      count_d  = '0;
      head_d   = '0;
      tail_d   = '0;
      acount_d = '0;
      ahead_d  = '0;
      atail_d  = '0;
    end else begin
      for (int i = 0; i < INSTR_PER_FETCH; i++) begin
        if (i < accept) begin
          widx          = tail_q + PTRW'(i);
          instr_d[widx] = instr_i[i*32 +: 32];
          addr_d[widx]  = addr_i[i*64 +: 64];
          ex_d[widx]    = exception_i;
          cf_d[widx]    = !exception_i && has_taken && (i == int'(first_taken));
        end
      end
      tail_d  = tail_q + PTRW'(accept);
      head_d  = head_q + PTRW'(npop);
      count_d = CNTW'(int'(count_q) + accept - npop);

      if (push_target) begin
        paddr_d[atail_q] = predict_address_i;
        atail_d          = aidx(atail_q, 1);
      end
      ahead_d  = aidx(ahead_q, apop);
      acount_d = ACNTW'(int'(acount_q) + (push_target ? 1 : 0) - apop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      acount_q <= '0;
      ahead_q  <= '0;
      atail_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        addr_q[i]  <= '0;
        ex_q[i]    <= 1'b0;
        cf_q[i]    <= 1'b0;
      end
      for (int i = 0; i < ADDR_DEPTH; i++) begin
        paddr_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      acount_q <= acount_d;
      ahead_q  <= ahead_d;
      atail_q  <= atail_d;
      instr_q  <= instr_d;
      addr_q   <= addr_d;
      ex_q     <= ex_d;
      cf_q     <= cf_d;
      paddr_q  <= paddr_d;
    end
  end

  // Acks must be a thermometer-coded subset of the valid lanes.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (((fetch_ack_i & ~fetch_valid_o) == '0) &&
              (((fetch_ack_i + ACK_ONE) & fetch_ack_i) == '0));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_queue_multi_issue.sv
`default_nettype none
// =============================================================================
// Module  : tb_instr_queue_multi_issue
// Brief   : Directed self-checking bench for instr_queue_multi_issue.
// Revision: 1.0
// =============================================================================
module tb_instr_queue_multi_issue;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic [127:0]  instr_i;
  logic [255:0]  addr_i;
  logic [3:0]    valid_i;
  logic          exception_i;
  logic [63:0]   predict_address_i;
  logic [3:0]    taken_i;
  logic [1:0]    branch_index_o;
  logic          replay_o;
  logic [63:0]   replay_addr_o;
  logic [63:0]   fetch_instr_o;
  logic [127:0]  fetch_addr_o;
  logic [1:0]    fetch_ex_o;
  logic [1:0]    fetch_cf_o;
  logic [127:0]  fetch_predict_addr_o;
  logic [1:0]    fetch_valid_o;
  logic [1:0]    fetch_ack_i;

  int n_cmp = 0;
  int n_err = 0;

  instr_queue_multi_issue #(
    .INSTR_PER_FETCH(4), .ISSUE_WIDTH(2), .DEPTH(8), .ADDR_DEPTH(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .instr_i(instr_i), .addr_i(addr_i), .valid_i(valid_i),
    .exception_i(exception_i), .predict_address_i(predict_address_i),
    .taken_i(taken_i), .branch_index_o(branch_index_o),
    .replay_o(replay_o), .replay_addr_o(replay_addr_o),
    .fetch_instr_o(fetch_instr_o), .fetch_addr_o(fetch_addr_o),
    .fetch_ex_o(fetch_ex_o), .fetch_cf_o(fetch_cf_o),
    .fetch_predict_addr_o(fetch_predict_addr_o),
    .fetch_valid_o(fetch_valid_o), .fetch_ack_i(fetch_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush_i           = 1'b0;
    valid_i           = '0;
    taken_i           = '0;
    exception_i       = 1'b0;
    predict_address_i = '0;
    fetch_ack_i       = '0;
  endtask

  // Slot i carries PC base+4*i and instruction word {A5A5, PC[15:0]}.
  task automatic drive(input logic [63:0] base, input logic [3:0] v, input logic [3:0] t,
                       input logic [63:0] tgt, input logic ex);
    logic [63:0] a;
    for (int i = 0; i < 4; i++) begin
      a                  = base + 64'(4 * i);
      addr_i[i*64 +: 64] = a;
      instr_i[i*32 +: 32] = {16'hA5A5, a[15:0]};
    end
    valid_i           = v;
    taken_i           = t;
    predict_address_i = tgt;
    exception_i       = ex;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    idle();
    #1;
  endtask

  initial begin
    idle();
    instr_i = '0;
    addr_i  = '0;
    rst_ni  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
    chk("reset_valid", 64'(fetch_valid_o), 64'h0);
    chk("reset_replay", 64'(replay_o), 64'h0);
    chk("reset_replay_addr", replay_addr_o, 64'h0);

    // Plain packet of four, then drained two per cycle.
    drive(64'h1000, 4'b1111, 4'b0000, 64'h0, 1'b0);
    #1;
    chk("plain_replay", 64'(replay_o), 64'h0);
    tick();
    chk("plain_valid", 64'(fetch_valid_o), 64'h3);
    chk("plain_pc0", fetch_addr_o[63:0], 64'h1000);
    chk("plain_pc1", fetch_addr_o[127:64], 64'h1004);
    chk("plain_instr1", 64'(fetch_instr_o[63:32]), 64'hA5A51004);
    fetch_ack_i = 2'b11;
    tick();
    chk("drain_pc0", fetch_addr_o[63:0], 64'h1008);
    fetch_ack_i = 2'b11;
    tick();
    chk("drain_empty", 64'(fetch_valid_o), 64'h0);

    // Taken branch in slot 1 truncates the packet after it.
    drive(64'h3000, 4'b1111, 4'b0010, 64'h8000, 1'b0);
    #1;
    chk("br_index", 64'(branch_index_o), 64'h1);
    chk("br_replay", 64'(replay_o), 64'h0);
    tick();
    chk("br_count", 64'(dut.count_q), 64'd2);
    chk("br_cf", 64'(fetch_cf_o), 64'h2);
    chk("br_pred1", fetch_predict_addr_o[127:64], 64'h8000);

    // Fill to 6, then a packet of 4 only partly fits.
    drive(64'h4000, 4'b1111, 4'b0000, 64'h0, 1'b0);
    tick();
    drive(64'h2000, 4'b1111, 4'b0000, 64'h0, 1'b0);
    #1;
    chk("part_replay", 64'(replay_o), 64'h1);
    chk("part_replay_addr", replay_addr_o, 64'h2008);
    tick();
    chk("part_count", 64'(dut.count_q), 64'd8);

    // Full queue: same-cycle ack gives the push no credit.
    fetch_ack_i = 2'b11;
    drive(64'h5000, 4'b1111, 4'b0000, 64'h0, 1'b0);
    #1;
    chk("full_replay", 64'(replay_o), 64'h1);
    chk("full_replay_addr", replay_addr_o, 64'h5000);
    tick();
    chk("full_count", 64'(dut.count_q), 64'd6);
    chk("full_pc0", fetch_addr_o[63:0], 64'h4000);

    // Fill the address FIFO with two single-slot taken packets.
    fetch_ack_i = 2'b11;
    drive(64'h6000, 4'b0001, 4'b0001, 64'h9000, 1'b0);
    tick();
    fetch_ack_i = 2'b11;
    drive(64'h6100, 4'b0001, 4'b0001, 64'h9100, 1'b0);
    tick();
    chk("afill_count", 64'(dut.count_q), 64'd4);
    drive(64'h7000, 4'b0011, 4'b0001, 64'hA000, 1'b0);
    #1;
    chk("afull_replay", 64'(replay_o), 64'h1);
    chk("afull_replay_addr", replay_addr_o, 64'h7000);
    tick();
    chk("afull_count", 64'(dut.count_q), 64'd4);
    fetch_ack_i = 2'b11;
    tick();
    chk("afull_cf", 64'(fetch_cf_o), 64'h3);
    chk("afull_pred0", fetch_predict_addr_o[63:0], 64'h9000);
    chk("afull_pred1", fetch_predict_addr_o[127:64], 64'h9100);
    fetch_ack_i = 2'b01;
    tick();
    chk("afree_valid", 64'(fetch_valid_o), 64'h1);
    drive(64'h7000, 4'b0001, 4'b0001, 64'hA000, 1'b0);
    #1;
    chk("afree_replay", 64'(replay_o), 64'h0);
    tick();
    chk("afree_cf", 64'(fetch_cf_o), 64'h3);
    chk("afree_pred0", fetch_predict_addr_o[63:0], 64'h9100);
    chk("afree_pred1", fetch_predict_addr_o[127:64], 64'hA000);

    // Flush beats a same-cycle push and ack.
    fetch_ack_i = 2'b11;
    flush_i     = 1'b1;
    drive(64'hD000, 4'b1111, 4'b0000, 64'h0, 1'b0);
    #1;
    chk("flush_replay", 64'(replay_o), 64'h0);
    tick();
    chk("flush_valid", 64'(fetch_valid_o), 64'h0);
    chk("flush_count", 64'(dut.count_q), 64'd0);

    // Faulting packet keeps only slot 0, marked ex and not cf.
    drive(64'hC000, 4'b1111, 4'b0100, 64'hE000, 1'b1);
    #1;
    chk("exc_replay", 64'(replay_o), 64'h0);
    tick();
    chk("exc_valid", 64'(fetch_valid_o), 64'h1);
    chk("exc_ex", 64'(fetch_ex_o[0]), 64'h1);
    chk("exc_cf", 64'(fetch_cf_o[0]), 64'h0);
    chk("exc_pc0", fetch_addr_o[63:0], 64'hC000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
